// File: rtl/systolic_result_drain_pkg.sv
// Shared types and defaults for the systolic result drain: read FSM encoding and element addressing.
package systolic_result_drain_pkg;

  localparam int unsigned ROWS_DEF      = 2;
  localparam int unsigned COLS_DEF      = 2;
  localparam int unsigned ACC_WIDTH_DEF = 9;
  localparam int unsigned OUT_WIDTH_DEF = 4;
  localparam int unsigned SHIFT_W_DEF   = 4;
  localparam int unsigned SIGNED_DEF    = 0;

  typedef enum logic {
    R_EMPTY  = 1'b0,
    R_STREAM = 1'b1
  } rd_state_e;

  // Bit offset of element [r][c] in a flattened row-major matrix.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                           input int unsigned cols, input int unsigned w);
    return (r * cols + c) * w;
  endfunction

endpackage

// File: rtl/systolic_requant_sat.sv
// One-element requantizer: round-to-nearest, right shift, saturate ACC_WIDTH -> OUT_WIDTH.
module systolic_requant_sat #(
  parameter int unsigned ACC_WIDTH = 9,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned SHIFT_W   = 4,
  parameter int unsigned SIGNED    = 0
) (
  input  logic [ACC_WIDTH-1:0] i_x,
  input  logic [SHIFT_W-1:0]   i_shift,
  output logic [OUT_WIDTH-1:0] o_y
);

  localparam int unsigned TW = ACC_WIDTH + 1;
  localparam int MAX_V = (SIGNED != 0) ? int'(2 ** (OUT_WIDTH - 1)) - 1 : int'(2 ** OUT_WIDTH) - 1;
  localparam int MIN_V = (SIGNED != 0) ? -int'(2 ** (OUT_WIDTH - 1)) : 0;

  logic              w_neg;
  logic              w_big_shift;
  logic [TW-1:0]     w_x_ext;
  logic [TW-1:0]     w_off;
  logic [TW-1:0]     w_t;
  logic [TW-1:0]     w_y;
  logic signed [TW:0] w_y_s;

  always_comb begin
    w_neg   = (SIGNED != 0) && i_x[ACC_WIDTH-1];
    w_x_ext = {w_neg, i_x};
    w_off   = (i_shift == '0) ? '0 : (TW'(1) << (i_shift - SHIFT_W'(1)));
    w_t     = w_x_ext + w_off;
    if (SIGNED != 0) w_y = TW'($signed(w_t) >>> i_shift);
    else             w_y = w_t >> i_shift;
    w_y_s   = $signed({(SIGNED != 0) && w_y[TW-1], w_y});
    // Shifting by the full accumulator width leaves only the sign.
    w_big_shift = 32'(i_shift) >= ACC_WIDTH;
    if (w_big_shift)                    o_y = w_neg ? '1 : '0;
    else if (w_y_s > (TW + 1)'(MAX_V))  o_y = OUT_WIDTH'(MAX_V);
    else if (w_y_s < (TW + 1)'(MIN_V))  o_y = OUT_WIDTH'(MIN_V);
    else                                o_y = w_y_s[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures finished C matrices into a 2-slot ping-pong buffer and streams requantized rows
// on a valid/ready port; dropped matrices raise a sticky overflow flag.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int unsigned SHIFT_W   = SHIFT_W_DEF,
  parameter int unsigned SIGNED    = SIGNED_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          c_in_valid,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] c_in_flat,
  input  logic [SHIFT_W-1:0]            shift,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [COLS*OUT_WIDTH-1:0]     m_data,
  output logic [$clog2(ROWS):0]         m_row,
  output logic                          m_last,
  output logic                          can_accept,
  output logic                          ovf_sticky,
  input  logic                          ovf_clear
);

  localparam int unsigned RW  = $clog2(ROWS) + 1;
  localparam int unsigned MW  = ROWS * COLS * ACC_WIDTH;
  localparam int unsigned RBW = COLS * ACC_WIDTH;
  localparam int unsigned DW  = COLS * OUT_WIDTH;

  logic [MW-1:0]      r_mat   [2];
  logic [SHIFT_W-1:0] r_shift [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [RW-1:0]      r_rd_row;
  rd_state_e          r_state;

  logic               w_xfer;
  logic               w_pop_last;
  logic               w_free;
  logic               w_cap;
  logic               w_drop;
  logic               w_sel_slot;
  logic [RW-1:0]      w_sel_row;
  logic [MW-1:0]      w_sel_mat;
  logic [SHIFT_W-1:0] w_sel_shift;
  logic [RBW-1:0]     w_row_elems;
  logic [DW-1:0]      w_rq_data;

  assign w_xfer     = m_valid & m_ready;
  assign w_pop_last = w_xfer & m_last;
  // A slot draining its final row this cycle counts as free.
  assign w_free     = (r_count != 2'd2) | w_pop_last;
  assign w_cap      = c_in_valid & w_free;
  assign w_drop     = c_in_valid & ~w_free;
  assign can_accept = (r_count != 2'd2);

  // Row that will be presented on m_* after this edge, if one is loaded.
  assign w_sel_slot  = w_pop_last ? ~r_rd_ptr : r_rd_ptr;
  assign w_sel_row   = (r_state == R_STREAM && w_xfer && !m_last) ? r_rd_row + RW'(1) : '0;
  assign w_sel_mat   = r_mat[w_sel_slot];
  assign w_sel_shift = r_shift[w_sel_slot];

  always_comb begin
    w_row_elems = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (w_sel_row == RW'(r)) w_row_elems = w_sel_mat[elem_lsb(r, 0, COLS, ACC_WIDTH) +: RBW];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_rq
    systolic_requant_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT_W   (SHIFT_W),
      .SIGNED    (SIGNED)
    ) u_rq (
      .i_x     (w_row_elems[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_shift (w_sel_shift),
      .o_y     (w_rq_data[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat      <= '{default: '0};
      r_shift    <= '{default: '0};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_rd_row   <= '0;
      r_state    <= R_EMPTY;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_row      <= '0;
      m_last     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (w_cap) begin
        r_mat[r_wr_ptr]   <= c_in_flat;
        r_shift[r_wr_ptr] <= shift;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_drop)         ovf_sticky <= 1'b1;
      else if (ovf_clear) ovf_sticky <= 1'b0;
      r_count <= r_count + 2'(w_cap) - 2'(w_pop_last);

      case (r_state)
        R_EMPTY: begin
          if (r_count != 2'd0) begin
            m_valid  <= 1'b1;
            m_data   <= w_rq_data;
            m_row    <= w_sel_row;
            m_last   <= (w_sel_row == RW'(ROWS - 1));
            r_rd_row <= '0;
            r_state  <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (w_xfer) begin
            if (m_last) begin
              r_rd_row <= '0;
              r_rd_ptr <= ~r_rd_ptr;
              // Chain straight into the other slot only when it already holds a matrix.
              if (r_count == 2'd2) begin
                m_data <= w_rq_data;
                m_row  <= w_sel_row;
                m_last <= (w_sel_row == RW'(ROWS - 1));
              end else begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                r_state <= R_EMPTY;
              end
            end else begin
              r_rd_row <= r_rd_row + RW'(1);
              m_data   <= w_rq_data;
              m_row    <= w_sel_row;
              m_last   <= (w_sel_row == RW'(ROWS - 1));
            end
          end
        end
        default: r_state <= R_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: directed corner cases, a signed requant table,
// and randomized traffic against a queue-based reference model.
module tb_systolic_result_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_in_valid;
  logic [35:0] c_in_flat;
  logic [3:0]  shift;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_row;
  logic        m_last;
  logic        can_accept;
  logic        ovf_sticky;
  logic        ovf_clear;

  logic [8:0]  sq_x;
  logic [3:0]  sq_s;
  logic [3:0]  sq_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(
    .ROWS(2), .COLS(2), .ACC_WIDTH(9), .OUT_WIDTH(4), .SHIFT_W(4), .SIGNED(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_in_valid (c_in_valid),
    .c_in_flat  (c_in_flat),
    .shift      (shift),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_last     (m_last),
    .can_accept (can_accept),
    .ovf_sticky (ovf_sticky),
    .ovf_clear  (ovf_clear)
  );

  systolic_requant_sat #(
    .ACC_WIDTH(9), .OUT_WIDTH(4), .SHIFT_W(4), .SIGNED(1)
  ) u_sq (
    .i_x     (sq_x),
    .i_shift (sq_s),
    .o_y     (sq_y)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic       last;
  } row_t;

  typedef struct {
    logic [8:0] x;
    logic [3:0] s;
    logic [3:0] y;
  } sq_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requant using plain integer arithmetic on the element value.
  function automatic int rq_ref(input int x, input int s, input bit sgn);
    int t;
    int lo;
    int hi;
    lo = sgn ? -8 : 0;
    hi = sgn ? 7 : 15;
    if (s >= 9) return (x < 0) ? 15 : 0;
    t = x + ((s > 0) ? (1 << (s - 1)) : 0);
    t = t >>> s;
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return t & 15;
  endfunction

  function automatic row_t exp_row(input logic [35:0] f, input logic [3:0] sh, input int r);
    row_t e;
    logic [8:0] b;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      b = f[(r*2+c)*9 +: 9];
      e.data[c*4 +: 4] = 4'(rq_ref(int'(b), int'(sh), 1'b0));
    end
    e.row  = 2'(r);
    e.last = (r == 1);
    return e;
  endfunction

  function automatic logic [35:0] pack(input int a00, input int a01, input int a10, input int a11);
    return {9'(a11), 9'(a10), 9'(a01), 9'(a00)};
  endfunction

  // Reference model: queue of rows still owed plus the number of matrices held.
  row_t        exp_q[$];
  int          held     = 0;
  bit          exp_ovf  = 1'b0;
  int          n_xfer   = 0;
  bit          prev_stall = 1'b0;
  logic [11:0] prev_out;
  bit          mon_pop_last;
  bit          mon_acc;
  row_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held       = 0;
      exp_ovf    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      mon_pop_last = 1'b0;
      chk("ovf_sticky", int'(ovf_sticky), int'(exp_ovf));
      chk("can_accept", int'(can_accept), (held < 2) ? 1 : 0);
      if (prev_stall)
        chk("hold_stable", int'({m_valid, m_data, m_row, m_last}), int'({1'b1, prev_out[10:0]}));
      if (m_valid && m_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("row_unexpected", int'({m_data, m_row, m_last}), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("row_data", int'({m_data, m_row, m_last}), int'(mon_e));
          mon_pop_last = mon_e.last;
        end
      end
      mon_acc = c_in_valid && (held < 2 || mon_pop_last);
      if (mon_acc) begin
        exp_q.push_back(exp_row(c_in_flat, shift, 0));
        exp_q.push_back(exp_row(c_in_flat, shift, 1));
        held++;
      end
      if (mon_pop_last) held--;
      if (c_in_valid && !mon_acc) exp_ovf = 1'b1;
      else if (ovf_clear)         exp_ovf = 1'b0;
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_data, m_row, m_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [35:0] m, input logic [3:0] s);
    c_in_valid = 1'b1;
    c_in_flat  = m;
    shift      = s;
    tick();
    c_in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    rst_n      = 1'b0;
    c_in_valid = 1'b0;
    c_in_flat  = '0;
    shift      = '0;
    m_ready    = 1'b0;
    ovf_clear  = 1'b0;
    tick();
    if (check) begin
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_row", int'(m_row), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_can_accept", int'(can_accept), 1);
      chk("rst_ovf", int'(ovf_sticky), 0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  sq_vec_t vt[14];
  logic [35:0] mat_a;
  logic [35:0] mat_b;
  logic [35:0] mat_c;
  int x0;
  int sx;

  initial begin
    // Signed requant table: x, shift, expected 4-bit result.
    vt[0]  = '{9'h1FD, 4'd1,  4'hF};
    vt[1]  = '{9'h138, 4'd0,  4'h8};
    vt[2]  = '{9'd100, 4'd0,  4'h7};
    vt[3]  = '{9'd5,   4'd0,  4'h5};
    vt[4]  = '{9'h1F8, 4'd0,  4'h8};
    vt[5]  = '{9'h1F7, 4'd0,  4'h8};
    vt[6]  = '{9'd7,   4'd0,  4'h7};
    vt[7]  = '{9'h1FF, 4'd9,  4'hF};
    vt[8]  = '{9'd100, 4'd9,  4'h0};
    vt[9]  = '{9'h100, 4'd15, 4'hF};
    vt[10] = '{9'd13,  4'd2,  4'h3};
    vt[11] = '{9'h1F3, 4'd2,  4'hD};
    vt[12] = '{9'h0FF, 4'd8,  4'h1};
    vt[13] = '{9'h100, 4'd8,  4'hF};
    for (int i = 0; i < 14; i++) begin
      sq_x = vt[i].x;
      sq_s = vt[i].s;
      #1;
      chk($sformatf("sq_vec%0d", i), int'(sq_y), int'(vt[i].y));
    end
    for (int i = 0; i < 200; i++) begin
      sq_x = 9'($urandom);
      sq_s = 4'($urandom);
      #1;
      sx = sq_x[8] ? int'(sq_x) - 512 : int'(sq_x);
      chk("sq_rand", int'(sq_y), rq_ref(sx, int'(sq_s), 1'b1));
    end

    do_reset(1'b1);

    // Basic shift-by-5 matrix: first row one cycle after capture.
    mat_a = pack(450, 10, 7, 0);
    m_ready = 1'b1;
    send(mat_a, 4'd5);
    @(negedge clk); chk("t1_latency", int'(m_valid), 0);
    @(negedge clk);
    chk("t1_r0_valid", int'(m_valid), 1);
    chk("t1_r0", int'({m_data, m_row, m_last}), int'({8'h0E, 2'd0, 1'b0}));
    @(negedge clk);
    chk("t1_r1", int'({m_valid, m_data, m_row, m_last}), int'({1'b1, 8'h00, 2'd1, 1'b1}));
    @(negedge clk); chk("t1_done", int'(m_valid), 0);

    // Shift 0: saturation of 450.
    tick();
    send(mat_a, 4'd0);
    @(negedge clk);
    @(negedge clk); chk("t2_r0", int'({m_data, m_row, m_last}), int'({8'hAF, 2'd0, 1'b0}));
    @(negedge clk); chk("t2_r1", int'({m_data, m_row, m_last}), int'({8'h07, 2'd1, 1'b1}));
    chk("t2_ovf", int'(ovf_sticky), 0);

    // Stalled consumer: two stored, third dropped (set beats a simultaneous clear).
    do_reset(1'b0);
    mat_b = pack($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511), 3);
    mat_c = pack(1, 2, 3, 4);
    send(mat_a, 4'd5);
    tick(); tick(); tick();
    send(mat_b, 4'd2);
    chk("t3_full", int'(can_accept), 0);
    tick(); tick(); tick();
    c_in_valid = 1'b1; c_in_flat = mat_c; shift = 4'd0; ovf_clear = 1'b1;
    tick();
    c_in_valid = 1'b0; ovf_clear = 1'b0;
    chk("t3_ovf_set", int'(ovf_sticky), 1);
    chk("t3_stall_row", int'({m_valid, m_row}), int'({1'b1, 2'd0}));
    x0 = n_xfer;
    m_ready = 1'b1;
    drain("t3_drain", 50);
    tick(); tick();
    chk("t3_rows", n_xfer - x0, 4);
    chk("t3_idle", int'(m_valid), 0);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t3_ovf_clr", int'(ovf_sticky), 0);

    // Full buffer, capture coincides with final-row pop: accepted and streamed seamlessly.
    do_reset(1'b0);
    send(mat_a, 4'd0);
    send(mat_b, 4'd2);
    tick(); tick();
    m_ready = 1'b1;
    tick();
    c_in_valid = 1'b1; c_in_flat = mat_c; shift = 4'd1;
    tick();
    c_in_valid = 1'b0;
    chk("t4_no_ovf", int'(ovf_sticky), 0);
    chk("t4_full", int'(can_accept), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_seamless%0d", i), int'({m_valid, m_row}), int'({1'b1, 2'(i & 1)}));
    end
    @(negedge clk); chk("t4_done", int'(m_valid), 0);
    chk("t4_queue", exp_q.size(), 0);

    // Asynchronous reset while a row is stalled.
    tick();
    m_ready = 1'b0;
    send(mat_a, 4'd3);
    tick(); tick();
    chk("t6_pre_valid", int'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(m_valid), 0);
    chk("t6_can_accept", int'(can_accept), 1);
    tick(); tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", int'(m_valid), 0);
    end

    // Randomized traffic against the reference model.
    tick();
    for (int i = 0; i < 1500; i++) begin
      c_in_valid = ($urandom_range(0, 5) == 0);
      c_in_flat  = 36'({$urandom(), $urandom()});
      shift      = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      m_ready    = ($urandom_range(0, 9) < 7);
      ovf_clear  = ($urandom_range(0, 19) == 0);
      tick();
    end
    c_in_valid = 1'b0;
    ovf_clear  = 1'b0;
    m_ready    = 1'b1;
    drain("rand_drain", 100);
    tick(); tick();
    chk("rand_idle", int'(m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
